// File: rtl/cache_ctrl_pkg.sv
// Shared constants, FSM state type and address field helpers for the 4-way cache controller.
package cache_ctrl_pkg;
  localparam int IDX_W = 8;
  localparam int TAG_W = 22;
  localparam int WAYS  = 4;
  localparam int SETS  = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    RESP     = 3'd5
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:32-TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[IDX_W+1:2];
  endfunction
endpackage

// File: rtl/cache_plru4.sv
// Tree pseudo-LRU for one 4-way set: bit2 = root, bit1 = ways 0/1, bit0 = ways 2/3; 0 points left.
module cache_plru4 (
  input  logic [2:0] i_bits,
  input  logic [1:0] i_acc_way,
  output logic [1:0] o_victim,
  output logic [2:0] o_next_bits
);
  always_comb begin
    o_victim    = i_bits[2] ? {1'b1, i_bits[0]} : {1'b0, i_bits[1]};
    o_next_bits = i_bits;
    // Point every node on the accessed way's path at the other subtree.
    o_next_bits[2] = ~i_acc_way[1];
    if (!i_acc_way[1]) o_next_bits[1] = ~i_acc_way[0];
    else               o_next_bits[0] = ~i_acc_way[0];
  end
endmodule

// File: rtl/cache_ctrl_4way.sv
// Sequencing controller for a 4-way write-through cache with tree pLRU replacement.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl_4way
  import cache_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [31:0]           cpu_req_addr,
  input  logic [31:0]           cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [31:0]           cpu_resp_rdata,
  output logic                  cpu_resp_hit,
  output logic [IDX_W-1:0]      arr_idx,
  output logic                  arr_rd_en,
  input  logic [WAYS*TAG_W-1:0] arr_tag_q,
  input  logic [WAYS*32-1:0]    arr_data_q,
  output logic [WAYS-1:0]       arr_wr_en,
  output logic [TAG_W-1:0]      arr_wr_tag,
  output logic [31:0]           arr_wr_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [31:0]           mem_req_addr,
  output logic [31:0]           mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_rdata,
`ifdef CACHE_STATS_EN
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
`endif
  output logic [2:0]            dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload stay stable until then. cpu_resp_valid is a one-cycle pulse.

  state_t            r_state, w_next_state;
  logic              r_we, r_hit;
  logic [31:0]       r_addr, r_wdata, r_rdata;
  logic [1:0]        r_way;
  logic [WAYS-1:0]   r_valid [SETS];
  logic [2:0]        r_plru  [SETS];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [WAYS-1:0]   w_set_valid, w_hit_vec;
  logic              w_hit;
  logic [1:0]        w_hit_way, w_inv_way, w_plru_victim, w_victim, w_lookup_way, w_acc_way;
  logic [2:0]        w_plru_next;
  logic [31:0]       w_hit_data;

  assign w_idx        = addr_idx(r_addr);
  assign w_tag        = addr_tag(r_addr);
  assign w_set_valid  = r_valid[w_idx];
  assign w_hit        = |w_hit_vec;
  assign w_victim     = (&w_set_valid) ? w_plru_victim : w_inv_way;
  assign w_lookup_way = w_hit ? w_hit_way : w_victim;
  assign w_acc_way    = (r_state == FILL) ? r_way : w_lookup_way;
  assign w_hit_data   = arr_data_q[{w_hit_way, 5'd0} +: 32];
  assign dbg_state    = r_state;

  // Lowest-index way wins for both multiple hits and invalid-way selection.
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = 2'd0;
    w_inv_way = 2'd0;
    for (int w = 0; w < WAYS; w++)
      w_hit_vec[w] = w_set_valid[w] && (arr_tag_q[w*TAG_W +: TAG_W] == w_tag);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w])    w_hit_way = 2'(w);
      if (!w_set_valid[w]) w_inv_way = 2'(w);
    end
  end

  cache_plru4 u_plru (
    .i_bits      (r_plru[w_idx]),
    .i_acc_way   (w_acc_way),
    .o_victim    (w_plru_victim),
    .o_next_bits (w_plru_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_hit   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_way   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: if (cpu_req_valid) begin
          r_we    <= cpu_req_we;
          r_addr  <= cpu_req_addr & ~32'h3;
          r_wdata <= cpu_req_wdata;
        end
        LOOKUP: begin
          r_hit   <= w_hit;
          r_way   <= w_lookup_way;
          r_rdata <= (!r_we && w_hit) ? w_hit_data : '0;
          if (r_we || w_hit) r_plru[w_idx] <= w_plru_next;
          if (r_we) r_valid[w_idx][w_lookup_way] <= 1'b1;
        end
        MEM_WAIT: if (mem_resp_valid) r_rdata <= mem_resp_rdata;
        FILL: begin
          r_valid[w_idx][r_way] <= 1'b1;
          r_plru[w_idx]         <= w_plru_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (cpu_req_valid) w_next_state = LOOKUP;
      LOOKUP:   w_next_state = (!r_we && w_hit) ? RESP : MEM_REQ;
      MEM_REQ:  if (mem_req_ready) w_next_state = r_we ? RESP : MEM_WAIT;
      MEM_WAIT: if (mem_resp_valid) w_next_state = FILL;
      FILL:     w_next_state = RESP;
      RESP:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    cpu_req_ready  = (r_state == IDLE);
    cpu_resp_valid = (r_state == RESP);
    cpu_resp_rdata = (r_state == RESP) ? r_rdata : '0;
    cpu_resp_hit   = (r_state == RESP) && r_hit;
    arr_rd_en      = (r_state == IDLE) && cpu_req_valid;
    arr_idx        = arr_rd_en ? addr_idx(cpu_req_addr) : w_idx;
    arr_wr_en      = '0;
    arr_wr_tag     = '0;
    arr_wr_data    = '0;
    if (r_state == LOOKUP && r_we) begin
      arr_wr_en   = 4'b0001 << w_lookup_way;
      arr_wr_tag  = w_tag;
      arr_wr_data = r_wdata;
    end else if (r_state == FILL) begin
      arr_wr_en   = 4'b0001 << r_way;
      arr_wr_tag  = w_tag;
      arr_wr_data = r_rdata;
    end
    mem_req_valid = (r_state == MEM_REQ);
    mem_req_we    = mem_req_valid && r_we;
    mem_req_addr  = mem_req_valid ? r_addr : '0;
    mem_req_wdata = mem_req_we ? r_wdata : '0;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_stat_hits, r_stat_misses;

  // One count per transaction, taken in LOOKUP; both counters saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
    end else if (r_state == LOOKUP) begin
      if (w_hit && r_stat_hits != 32'hFFFF_FFFF)    r_stat_hits   <= r_stat_hits + 32'd1;
      if (!w_hit && r_stat_misses != 32'hFFFF_FFFF) r_stat_misses <= r_stat_misses + 32'd1;
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
`endif
endmodule

// File: tb/tb_cache_ctrl_4way.sv
// Directed bench for cache_ctrl_4way: tag/data array model, RAM responder and response scoreboard.
module tb_cache_ctrl_4way;
  import cache_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0]           cpu_req_addr, cpu_req_wdata;
  logic                  cpu_resp_valid, cpu_resp_hit;
  logic [31:0]           cpu_resp_rdata;
  logic [IDX_W-1:0]      arr_idx;
  logic                  arr_rd_en;
  logic [WAYS*TAG_W-1:0] arr_tag_q;
  logic [WAYS*32-1:0]    arr_data_q;
  logic [WAYS-1:0]       arr_wr_en;
  logic [TAG_W-1:0]      arr_wr_tag;
  logic [31:0]           arr_wr_data;
  logic                  mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]           mem_req_addr, mem_req_wdata;
  logic                  mem_resp_valid;
  logic [31:0]           mem_resp_rdata;
  logic [2:0]            dbg_state;
`ifdef CACHE_STATS_EN
  logic [31:0]           stat_hits, stat_misses;
`endif

  cache_ctrl_4way dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
    .arr_idx(arr_idx), .arr_rd_en(arr_rd_en), .arr_tag_q(arr_tag_q), .arr_data_q(arr_data_q),
    .arr_wr_en(arr_wr_en), .arr_wr_tag(arr_wr_tag), .arr_wr_data(arr_wr_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
`ifdef CACHE_STATS_EN
    .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // External tag/data arrays: registered read, data valid the cycle after arr_rd_en.
  logic [TAG_W-1:0] m_tag  [SETS][WAYS];
  logic [31:0]      m_data [SETS][WAYS];
  always @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (arr_rd_en) begin
        arr_tag_q[w*TAG_W +: TAG_W] <= m_tag[arr_idx][w];
        arr_data_q[w*32 +: 32]      <= m_data[arr_idx][w];
      end
      if (arr_wr_en[w]) begin
        m_tag[arr_idx][w]  <= arr_wr_tag;
        m_data[arr_idx][w] <= arr_wr_data;
      end
    end
  end

  // Scoreboard state
  logic [32:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int wr_cnt, mem_cnt, lat;
  logic [WAYS-1:0]  last_wr_en;
  logic [TAG_W-1:0] last_wr_tag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction, starting and ending on a falling edge with the controller idle.
  // mem_lat = MEM_WAIT cycles until RAM data; stall = cycles mem_req_ready is held low.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_hit, input logic [31:0] exp_rdata,
                     input int mem_lat, input int stall);
    int n, stall_cnt, wait_cnt;
    logic hs_pend, req_seen, done;
    logic [32:0] exp;
    exp_q.push_back({exp_hit, exp_rdata});
    if (exp_hit) exp_hits++; else exp_misses++;
    wr_cnt = 0; mem_cnt = 0; lat = 0; last_wr_en = '0; last_wr_tag = '0;
    stall_cnt = 0; wait_cnt = 0; hs_pend = 1'b0; req_seen = 1'b0; done = 1'b0;
    chk("req_ready_idle", 64'(cpu_req_ready), 64'd1);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      if (cpu_resp_valid) begin
        done = 1'b1;
        lat  = n;
        exp  = exp_q.pop_front();
        chk("resp_hit", 64'(cpu_resp_hit), 64'(exp[32]));
        chk("resp_rdata", 64'(cpu_resp_rdata), 64'(exp[31:0]));
      end else begin
        if (arr_wr_en != '0) begin
          wr_cnt++;
          last_wr_en  = arr_wr_en;
          last_wr_tag = arr_wr_tag;
        end
        mem_resp_valid = 1'b0;
        if (hs_pend) begin
          wait_cnt++;
          if (!we && wait_cnt == mem_lat) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = exp_rdata;
          end
        end
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
          chk(req_seen ? "stall_mem_addr" : "mem_addr", 64'(mem_req_addr), 64'(addr & ~32'h3));
          chk(req_seen ? "stall_mem_we" : "mem_we", 64'(mem_req_we), 64'(we));
          chk("busy_req_ready", 64'(cpu_req_ready), 64'd0);
          if (we && !req_seen) chk("mem_wdata", 64'(mem_req_wdata), 64'(wdata));
          req_seen = 1'b1;
          if (stall_cnt >= stall) begin
            mem_req_ready = 1'b1;
            hs_pend = 1'b1;
            mem_cnt++;
          end else stall_cnt++;
        end
        @(negedge clk);
        n++;
      end
    end
    checks++;
    assert (done)
    else begin
      errors++;
      $error("FAIL resp_timeout observed=no response expected=response addr=%0h", addr);
    end
    if (!done) void'(exp_q.pop_front());
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] wd [4];
  logic [31:0] rd_a;
  logic [31:0] tags4 [4];
  logic [31:0] base4 [4];
  int bound;

  initial begin
    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    tags4[0] = 32'd0; tags4[1] = 32'd1; tags4[2] = 32'd3; tags4[3] = 32'd7;
    base4[0] = 32'h0; base4[1] = 32'h400; base4[2] = 32'hC00; base4[3] = 32'h1C00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_req_ready", 64'(cpu_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(cpu_resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(cpu_resp_rdata), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_arr_wr_en", 64'(arr_wr_en), 64'd0);
    chk("rst_arr_rd_en", 64'(arr_rd_en), 64'd0);
    chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold read miss filled into way0, then a read hit with 2-cycle latency.
    txn(1'b0, 32'h40, 32'h0, 1'b0, 32'd111, 3, 0);
    chk("miss_lat", 64'(lat), 64'd7);
    chk("miss_mem_cnt", 64'(mem_cnt), 64'd1);
    chk("miss_fill_way", 64'(last_wr_en), 64'b0001);
    chk("miss_fill_tag", 64'(last_wr_tag), 64'd0);
    txn(1'b0, 32'h43, 32'h0, 1'b1, 32'd111, 1, 0);
    chk("hit_lat", 64'(lat), 64'd2);
    chk("hit_mem_cnt", 64'(mem_cnt), 64'd0);
    chk("hit_wr_cnt", 64'(wr_cnt), 64'd0);

    // Four writes to set 16 occupy ways 0..3 in order; first one hits the filled line.
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      txn(1'b1, base4[i] + 32'h40, wd[i], (i == 0), 32'h0, 1, 0);
      chk("wr_way", 64'(last_wr_en), 64'(4'b0001 << i));
      chk("wr_tag", 64'(last_wr_tag), 64'(tags4[i]));
      chk("wr_mem_cnt", 64'(mem_cnt), 64'd1);
    end
    // Set full: pLRU picks way0; then 0x40 has been evicted.
    txn(1'b1, 32'h840, $urandom, 1'b0, 32'h0, 1, 0);
    chk("plru_wr_way", 64'(last_wr_en), 64'b0001);
    chk("plru_wr_tag", 64'(last_wr_tag), 64'd2);
    rd_a = $urandom;
    txn(1'b0, 32'h40, 32'h0, 1'b0, rd_a, 1, 0);
    chk("evict_lat", 64'(lat), 64'd5);
    chk("evict_fill_way", 64'(last_wr_en), 64'b0100);
    txn(1'b0, 32'h1C40, 32'h0, 1'b1, wd[3], 1, 0);

    // Set 17: fill ways 0..3, touch way1, and the next victim must be way2.
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      txn(1'b1, base4[i] + 32'h44, wd[i], 1'b0, 32'h0, $urandom_range(1, 3), 0);
    end
    txn(1'b0, 32'h444, 32'h0, 1'b1, wd[1], 1, 0);
    txn(1'b1, 32'h2044, $urandom, 1'b0, 32'h0, 1, 0);
    chk("plru_touch_way", 64'(last_wr_en), 64'b0100);
    chk("plru_touch_tag", 64'(last_wr_tag), 64'd8);

    // Read miss with mem_req_ready held low for 5 cycles.
    rd_a = $urandom;
    txn(1'b0, 32'h80, 32'h0, 1'b0, rd_a, 2, 5);
    chk("stall_lat", 64'(lat), 64'd11);
    txn(1'b0, 32'h80, 32'h0, 1'b1, rd_a, 1, 0);

    // Reset while waiting for RAM data; a late mem_resp_valid must be ignored.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'hC0;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    bound = 0;
    while (!mem_req_valid && bound < 20) begin
      @(negedge clk);
      bound++;
    end
    chk("rst_test_mem_req", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rst_test_in_wait", 64'(dbg_state), 64'(MEM_WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    chk("abort_req_ready", 64'(cpu_req_ready), 64'd1);
    chk("abort_resp_valid", 64'(cpu_resp_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("late_resp_ready", 64'(cpu_req_ready), 64'd1);
    chk("late_resp_valid", 64'(cpu_resp_valid), 64'd0);
    chk("late_resp_wr_en", 64'(arr_wr_en), 64'd0);
    @(negedge clk);
    chk("late_resp_idle", 64'(dbg_state), 64'(IDLE));

    // Valid bits were cleared: previously cached lines miss again.
    rd_a = $urandom;
    txn(1'b0, 32'hC0, 32'h0, 1'b0, rd_a, 2, 0);
    txn(1'b0, 32'hC0, 32'h0, 1'b1, rd_a, 1, 0);
    rd_a = $urandom;
    txn(1'b0, 32'h80, 32'h0, 1'b0, rd_a, 1, 0);
    chk("post_rst_fill_way", 64'(last_wr_en), 64'b0001);
    txn(1'b0, 32'h80, 32'h0, 1'b1, rd_a, 1, 0);

`ifdef CACHE_STATS_EN
    chk("stat_hits", 64'(stat_hits), 64'(exp_hits));
    chk("stat_misses", 64'(stat_misses), 64'(exp_misses));
`endif
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
